knn_engine: RTL and testbench

- Parametrised successor to the fixed 4-NN core.
- Holds one test point of DIM signed coordinates.
- Accepts a valid/ready stream of labelled data points and computes the squared Euclidean distance of each through a 2-stage pipeline.
- Keeps a sorted list of the K nearest points, then produces a majority-vote class label.
- Sits behind the peripheral's register interface; software loads the test point, streams data points, waits for done, then reads the list and class.

---
 rtl/knn_engine_pkg.sv | 22 ++
 rtl/knn_dist_pipe.sv | 99 +++++++++
 rtl/knn_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_knn_engine.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_engine_pkg.sv
// Shared definitions for the k-nearest-neighbour engine: FSM states and width helpers.
package knn_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_VOTE,
      ST_DONE
   } knn_state_e;

   // Distance width: squared (COORD_W+1)-bit difference summed over DIM terms, plus a spare bit.
   function automatic int dist_width(input int coord_w, input int dim);
      return 2 * (coord_w + 1) + $clog2(dim) + 1;
   endfunction

   // Select/index width that never collapses to zero bits.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/knn_dist_pipe.sv
// Distance pipeline: input register, per-coordinate squared difference, then sum of squares.
module knn_dist_pipe
   import knn_engine_pkg::*;
#(
   parameter int COORD_W = 16,
   parameter int DIM = 2,
   parameter int LABEL_W = 4,
   localparam int DIST_W = dist_width(COORD_W, DIM)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DIM*COORD_W-1:0]   test_point,
   input  logic                     in_valid,
   input  logic [DIM*COORD_W-1:0]   in_coord,
   input  logic [LABEL_W-1:0]       in_label,
   output logic                     out_valid,
   output logic [DIST_W-1:0]        out_dist,
   output logic [LABEL_W-1:0]       out_label,
   output logic                     busy
);

   localparam int DIFF_W = COORD_W + 1;
   localparam int SQ_W   = 2 * DIFF_W;

   logic                   s0_valid;
   logic [DIM*COORD_W-1:0] s0_coord;
   logic [LABEL_W-1:0]     s0_label;

   logic                   s1_valid;
   logic [SQ_W-1:0]        s1_sq [DIM];
   logic [LABEL_W-1:0]     s1_label;

   logic signed [DIFF_W-1:0] diff [DIM];
   logic [SQ_W-1:0]          sq_next [DIM];
   logic [DIST_W-1:0]        sum_next;

   // Capture the accepted point so the subtractors work from a registered copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_coord <= '0;
         s0_label <= '0;
      end else begin
         s0_valid <= in_valid;
         if (in_valid) begin
            s0_coord <= in_coord;
            s0_label <= in_label;
         end
      end
   end

   // Signed difference is one bit wider than a coordinate, so the square can never wrap.
   always_comb begin
      for (int k = 0; k < DIM; k++) begin
         diff[k] = DIFF_W'($signed(s0_coord[k*COORD_W +: COORD_W]))
                 - DIFF_W'($signed(test_point[k*COORD_W +: COORD_W]));
         sq_next[k] = SQ_W'(diff[k]) * SQ_W'(diff[k]);
      end
   end

   // Stage 1 holds one square per coordinate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_label <= '0;
         for (int k = 0; k < DIM; k++) s1_sq[k] <= '0;
      end else begin
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_label <= s0_label;
            for (int k = 0; k < DIM; k++) s1_sq[k] <= sq_next[k];
         end
      end
   end

   // Squares are non-negative, so zero-extension before the sum is exact.
   always_comb begin
      sum_next = '0;
      for (int k = 0; k < DIM; k++) sum_next = sum_next + DIST_W'(s1_sq[k]);
   end

   // Stage 2 presents the finished distance with its label to the list.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_dist  <= '0;
         out_label <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_dist  <= sum_next;
            out_label <= s1_label;
         end
      end
   end

   assign busy = s0_valid | s1_valid | out_valid;

endmodule

// File: rtl/knn_engine.sv
// k-nearest-neighbour engine: test point store, run FSM, sorted K-entry list and majority vote.
module knn_engine
   import knn_engine_pkg::*;
#(
   parameter int COORD_W = 16,
   parameter int DIM = 2,
   parameter int K = 4,
   parameter int LABEL_W = 4,
   localparam int DIST_W = dist_width(COORD_W, DIM),
   localparam int IDX_W = sel_width(DIM),
   localparam int RD_W = sel_width(K),
   localparam int CNT_W = $clog2(K + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     test_we,
   input  logic [IDX_W-1:0]         test_idx,
   input  logic [COORD_W-1:0]       test_coord,
   input  logic                     pt_valid,
   output logic                     pt_ready,
   input  logic [DIM*COORD_W-1:0]   pt_coord,
   input  logic [LABEL_W-1:0]       pt_label,
   input  logic                     pt_last,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         count,
   input  logic [RD_W-1:0]          rd_idx,
   output logic [DIST_W-1:0]        rd_dist,
   output logic [LABEL_W-1:0]       rd_label,
   output logic                     rd_valid,
   output logic [LABEL_W-1:0]       class_label
);

   knn_state_e state, state_next;

   logic                   list_clear;
   logic                   vote_en;
   logic [DIM*COORD_W-1:0] test_point;

   logic                   pipe_valid;
   logic [DIST_W-1:0]      pipe_dist;
   logic [LABEL_W-1:0]     pipe_label;
   logic                   pipe_busy;

   logic [DIST_W-1:0]      list_dist  [K];
   logic [LABEL_W-1:0]     list_label [K];
   logic [K-1:0]           list_valid;

   logic                   seen;
   logic [K-1:0]           hit;
   logic [K-1:0]           first;
   logic [DIST_W-1:0]      up_dist  [K];
   logic [LABEL_W-1:0]     up_label [K];
   logic [K-1:0]           up_valid;
   logic [DIST_W-1:0]      ins_dist  [K];
   logic [LABEL_W-1:0]     ins_label [K];
   logic [K-1:0]           ins_valid;

   logic [LABEL_W-1:0]     vote_label;
   int                     occ;
   int                     best;

   knn_dist_pipe #(
      .COORD_W (COORD_W),
      .DIM     (DIM),
      .LABEL_W (LABEL_W)
   ) u_pipe (
      .clk        (clk),
      .rst        (rst),
      .test_point (test_point),
      .in_valid   (pt_valid & pt_ready),
      .in_coord   (pt_coord),
      .in_label   (pt_label),
      .out_valid  (pipe_valid),
      .out_dist   (pipe_dist),
      .out_label  (pipe_label),
      .busy       (pipe_busy)
   );

   // State register for the run sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake/status outputs; start only counts when no run is active.
   always_comb begin
      state_next = state;
      pt_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      list_clear = 1'b0;
      vote_en    = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            done = (state == ST_DONE);
            if (start) begin
               list_clear = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            pt_ready = 1'b1;
            busy     = 1'b1;
            if (pt_valid && pt_last) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (!pipe_busy) state_next = ST_VOTE;
         end
         ST_VOTE: begin
            busy       = 1'b1;
            vote_en    = 1'b1;
            state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Test point is writable only between runs so a run always sees one consistent point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         test_point <= '0;
      end else if (test_we && (state == ST_IDLE || state == ST_DONE) && int'(test_idx) < DIM) begin
         test_point[test_idx*COORD_W +: COORD_W] <= test_coord;
      end
   end

   // Parallel compare: the first entry the new distance beats (or that is empty) takes it, the rest slide down.
   always_comb begin
      seen = 1'b0;
      hit  = '0;
      for (int i = 0; i < K; i++) begin
         seen   = seen | ~list_valid[i] | (pipe_dist < list_dist[i]);
         hit[i] = seen;
      end
      first = hit & ~(hit << 1);
      up_dist[0]  = '1;
      up_label[0] = '0;
      up_valid[0] = 1'b0;
      for (int i = 1; i < K; i++) begin
         up_dist[i]  = list_dist[i-1];
         up_label[i] = list_label[i-1];
         up_valid[i] = list_valid[i-1];
      end
      for (int i = 0; i < K; i++) begin
         if (first[i]) begin
            ins_dist[i]  = pipe_dist;
            ins_label[i] = pipe_label;
            ins_valid[i] = 1'b1;
         end else if (hit[i]) begin
            ins_dist[i]  = up_dist[i];
            ins_label[i] = up_label[i];
            ins_valid[i] = up_valid[i];
         end else begin
            ins_dist[i]  = list_dist[i];
            ins_label[i] = list_label[i];
            ins_valid[i] = list_valid[i];
         end
      end
   end

   // Sorted list storage; empty entries read as maximum distance so they lose every compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         list_valid <= '0;
         for (int i = 0; i < K; i++) begin
            list_dist[i]  <= '1;
            list_label[i] <= '0;
         end
      end else if (list_clear) begin
         list_valid <= '0;
         for (int i = 0; i < K; i++) begin
            list_dist[i]  <= '1;
            list_label[i] <= '0;
         end
      end else if (pipe_valid) begin
         list_valid <= ins_valid;
         for (int i = 0; i < K; i++) begin
            list_dist[i]  <= ins_dist[i];
            list_label[i] <= ins_label[i];
         end
      end
   end

   // Occupancy grows with each insertion and stops at K once the list is full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (list_clear) begin
         count <= '0;
      end else if (pipe_valid && hit[K-1] && count != CNT_W'(K)) begin
         count <= count + 1'b1;
      end
   end

   // Majority vote: scanning nearest-first with strict '>' lets the nearest label win ties.
   always_comb begin
      vote_label = '0;
      best       = 0;
      occ        = 0;
      for (int i = 0; i < K; i++) begin
         if (list_valid[i]) begin
            occ = 0;
            for (int j = 0; j < K; j++) begin
               if (list_valid[j] && list_label[j] == list_label[i]) occ = occ + 1;
            end
            if (occ > best) begin
               best       = occ;
               vote_label = list_label[i];
            end
         end
      end
   end

   // Result register loaded once per run in the vote state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             class_label <= '0;
      else if (list_clear) class_label <= '0;
      else if (vote_en)    class_label <= vote_label;
   end

   // Combinational read port onto the list.
   always_comb begin
      rd_valid = 1'b0;
      rd_dist  = '1;
      rd_label = '0;
      if (int'(rd_idx) < K) begin
         rd_valid = list_valid[rd_idx];
         rd_dist  = list_dist[rd_idx];
         rd_label = list_label[rd_idx];
      end
   end

endmodule

// File: tb/tb_knn_engine.sv
// Self-checking bench for knn_engine with a sort-and-tally reference model.
module tb_knn_engine;

   localparam int COORD_W = 16;
   localparam int DIM = 2;
   localparam int K = 4;
   localparam int LABEL_W = 4;
   localparam int DIST_W = 36;

   logic clk = 1'b0;
   logic rst;
   logic start, test_we;
   logic [0:0] test_idx;
   logic [COORD_W-1:0] test_coord;
   logic pt_valid, pt_ready, pt_last;
   logic [DIM*COORD_W-1:0] pt_coord;
   logic [LABEL_W-1:0] pt_label;
   logic busy, done;
   logic [2:0] count;
   logic [1:0] rd_idx;
   logic [DIST_W-1:0] rd_dist;
   logic [LABEL_W-1:0] rd_label;
   logic rd_valid;
   logic [LABEL_W-1:0] class_label;

   int tests_run = 0;
   int tests_failed = 0;

   longint tx, ty;
   longint run_dist[$];
   logic [3:0] run_lab[$];
   logic [35:0] exp_dist[K];
   logic [3:0] exp_lab[K];
   logic exp_valid[K];
   int exp_count;
   logic [3:0] exp_class;

   always #5 clk = ~clk;

   knn_engine #(
      .COORD_W (COORD_W),
      .DIM     (DIM),
      .K       (K),
      .LABEL_W (LABEL_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .test_we     (test_we),
      .test_idx    (test_idx),
      .test_coord  (test_coord),
      .pt_valid    (pt_valid),
      .pt_ready    (pt_ready),
      .pt_coord    (pt_coord),
      .pt_label    (pt_label),
      .pt_last     (pt_last),
      .busy        (busy),
      .done        (done),
      .count       (count),
      .rd_idx      (rd_idx),
      .rd_dist     (rd_dist),
      .rd_label    (rd_label),
      .rd_valid    (rd_valid),
      .class_label (class_label)
   );

   // Write both test-point coordinates and remember them for the model.
   task automatic set_test(input int x, input int y);
      tx = x;
      ty = y;
      test_we = 1'b1;
      test_idx = 1'b0;
      test_coord = 16'(x);
      @(posedge clk); #1;
      test_idx = 1'b1;
      test_coord = 16'(y);
      @(posedge clk); #1;
      test_we = 1'b0;
   endtask

   task automatic begin_run;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_dist.delete();
      run_lab.delete();
   endtask

   // Present one point and hold it until the engine takes it; the model records accepted points.
   task automatic send_point(input int x, input int y, input int lab, input bit last);
      int n;
      longint dx, dy;
      n = 0;
      pt_coord = {16'(y), 16'(x)};
      pt_label = 4'(lab);
      pt_last = last;
      pt_valid = 1'b1;
      while (!pt_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!pt_ready) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL accept_timeout: pt_ready=%0b after %0d cycles, required 1", pt_ready, n);
         pt_valid = 1'b0;
         pt_last = 1'b0;
         return;
      end
      @(posedge clk); #1;
      pt_valid = 1'b0;
      pt_last = 1'b0;
      dx = longint'(x) - tx;
      dy = longint'(y) - ty;
      run_dist.push_back(dx * dx + dy * dy);
      run_lab.push_back(4'(lab));
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (!done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL done_timeout: done=%0b after %0d cycles, required 1", done, edges);
      end
   endtask

   // Reference: stable selection of the K smallest distances, then a label tally over them.
   task automatic compute_model;
      bit taken[64];
      int tally[16];
      int n, bi, bt;
      n = run_dist.size();
      for (int j = 0; j < 64; j++) taken[j] = 1'b0;
      for (int j = 0; j < 16; j++) tally[j] = 0;
      exp_count = (n < K) ? n : K;
      for (int s = 0; s < K; s++) begin
         if (s < exp_count) begin
            bi = -1;
            for (int j = 0; j < n; j++)
               if (!taken[j] && (bi < 0 || run_dist[j] < run_dist[bi])) bi = j;
            taken[bi] = 1'b1;
            exp_dist[s] = 36'(run_dist[bi]);
            exp_lab[s] = run_lab[bi];
            exp_valid[s] = 1'b1;
         end else begin
            exp_dist[s] = '1;
            exp_lab[s] = '0;
            exp_valid[s] = 1'b0;
         end
      end
      for (int s = 0; s < exp_count; s++) tally[exp_lab[s]]++;
      exp_class = '0;
      bt = 0;
      for (int s = 0; s < exp_count; s++)
         if (tally[exp_lab[s]] > bt) begin
            bt = tally[exp_lab[s]];
            exp_class = exp_lab[s];
         end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({pt_ready, busy, done} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: ready/busy/done=%b required 000", {pt_ready, busy, done});
      end
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_count: got %0d required 0", count);
      end
      tests_run++;
      if (class_label !== 4'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_class: got %0d required 0", class_label);
      end
      for (int i = 0; i < K; i++) begin
         rd_idx = 2'(i);
         #1;
         tests_run++;
         if (rd_valid !== 1'b0 || rd_dist !== {DIST_W{1'b1}} || rd_label !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_entry%0d: valid=%0b dist=%0h label=%0d required 0/fffffffff/0",
                     i, rd_valid, rd_dist, rd_label);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_handshake;
      int edges;
      pt_valid = 1'b1;
      pt_coord = '0;
      pt_label = 4'd9;
      repeat (4) begin
         @(posedge clk); #1;
         tests_run++;
         if (pt_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_ready: got %0b required 0", pt_ready);
         end
      end
      pt_valid = 1'b0;
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL idle_no_accept: count=%0d required 0", count);
      end
      set_test(0, 0);
      begin_run;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: send_point(1, 0, 1, 1'b0);
            1: send_point(0, 2, 2, 1'b0);
            2: send_point(3, 0, 3, 1'b0);
            default: send_point(0, 1, 4, 1'b1);
         endcase
         if (i < 3) begin
            pt_coord = '0;
            pt_label = 4'd9;
            start = (i == 1);
            test_we = (i == 2);
            test_idx = 1'b0;
            test_coord = 16'd100;
            @(posedge clk); #1;
            start = 1'b0;
            test_we = 1'b0;
         end
      end
      wait_done(edges);
      compute_model;
      tests_run++;
      if (count !== 3'(exp_count)) begin
         tests_failed++;
         $display("[TB] FAIL toggle_count: got %0d required %0d", count, exp_count);
      end
      tests_run++;
      if (class_label !== exp_class) begin
         tests_failed++;
         $display("[TB] FAIL toggle_class: got %0d required %0d", class_label, exp_class);
      end
      for (int i = 0; i < K; i++) begin
         rd_idx = 2'(i);
         #1;
         tests_run++;
         if (rd_dist !== exp_dist[i] || rd_label !== exp_lab[i] || rd_valid !== exp_valid[i]) begin
            tests_failed++;
            $display("[TB] FAIL toggle_entry%0d: got %0d/L%0d/v%0b required %0d/L%0d/v%0b",
                     i, rd_dist, rd_label, rd_valid, exp_dist[i], exp_lab[i], exp_valid[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [35:0] e_d[4] = '{36'd1, 36'd2, 36'd4, 36'd25};
      logic [3:0] e_l[4] = '{4'd2, 4'd2, 4'd1, 4'd1};
      int edges;
      set_test(0, 0);
      begin_run;
      send_point(3, 4, 1, 1'b0);
      send_point(1, 1, 2, 1'b0);
      send_point(-2, 0, 1, 1'b0);
      send_point(5, 5, 3, 1'b0);
      send_point(0, 1, 2, 1'b1);
      wait_done(edges);
      tests_run++;
      if (edges != 5) begin
         tests_failed++;
         $display("[TB] FAIL done_latency: got %0d edges required 5", edges);
      end
      tests_run++;
      if (count !== 3'd4) begin
         tests_failed++;
         $display("[TB] FAIL basic_count: got %0d required 4", count);
      end
      tests_run++;
      if (class_label !== 4'd2) begin
         tests_failed++;
         $display("[TB] FAIL basic_class: got %0d required 2", class_label);
      end
      for (int i = 0; i < K; i++) begin
         rd_idx = 2'(i);
         #1;
         tests_run++;
         if (rd_dist !== e_d[i] || rd_label !== e_l[i] || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_entry%0d: got %0d/L%0d/v%0b required %0d/L%0d/v1",
                     i, rd_dist, rd_label, rd_valid, e_d[i], e_l[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_partial;
      int edges;
      set_test(0, 0);
      begin_run;
      send_point(2, 0, 5, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL list_early: count=%0d two edges after accept, required 0", count);
      end
      @(posedge clk); #1;
      rd_idx = 2'd0;
      #1;
      tests_run++;
      if (count !== 3'd1 || rd_dist !== 36'd4) begin
         tests_failed++;
         $display("[TB] FAIL list_latency: count=%0d dist=%0d three edges after accept, required 1/4",
                  count, rd_dist);
      end
      send_point(0, 1, 7, 1'b1);
      wait_done(edges);
      tests_run++;
      if (count !== 3'd2) begin
         tests_failed++;
         $display("[TB] FAIL partial_count: got %0d required 2", count);
      end
      tests_run++;
      if (class_label !== 4'd7) begin
         tests_failed++;
         $display("[TB] FAIL partial_class: got %0d required 7", class_label);
      end
      rd_idx = 2'd0;
      #1;
      tests_run++;
      if (rd_dist !== 36'd1 || rd_label !== 4'd7 || rd_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL partial_entry0: got %0d/L%0d/v%0b required 1/L7/v1", rd_dist, rd_label, rd_valid);
      end
      rd_idx = 2'd1;
      #1;
      tests_run++;
      if (rd_dist !== 36'd4 || rd_label !== 4'd5 || rd_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL partial_entry1: got %0d/L%0d/v%0b required 4/L5/v1", rd_dist, rd_label, rd_valid);
      end
      for (int i = 2; i < K; i++) begin
         rd_idx = 2'(i);
         #1;
         tests_run++;
         if (rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL partial_empty%0d: valid=%0b required 0", i, rd_valid);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ties;
      int edges;
      set_test(0, 0);
      begin_run;
      send_point(1, 0, 1, 1'b0);
      send_point(0, 1, 2, 1'b0);
      send_point(-1, 0, 3, 1'b1);
      wait_done(edges);
      for (int i = 0; i < 3; i++) begin
         rd_idx = 2'(i);
         #1;
         tests_run++;
         if (rd_dist !== 36'd1 || rd_label !== 4'(i + 1)) begin
            tests_failed++;
            $display("[TB] FAIL tie_order%0d: got %0d/L%0d required 1/L%0d", i, rd_dist, rd_label, i + 1);
         end
      end
      tests_run++;
      if (class_label !== 4'd1) begin
         tests_failed++;
         $display("[TB] FAIL tie_class: got %0d required 1", class_label);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_extremes;
      int edges;
      set_test(32767, 32767);
      begin_run;
      send_point(-32768, -32768, 6, 1'b1);
      wait_done(edges);
      rd_idx = 2'd0;
      #1;
      tests_run++;
      if (rd_dist !== 36'd8589672450 || rd_label !== 4'd6) begin
         tests_failed++;
         $display("[TB] FAIL extreme_dist: got %0d/L%0d required 8589672450/L6", rd_dist, rd_label);
      end
      tests_run++;
      if (class_label !== 4'd6 || count !== 3'd1) begin
         tests_failed++;
         $display("[TB] FAIL extreme_result: class=%0d count=%0d required 6/1", class_label, count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int edges, npts, rx, ry;
      bit wide;
      for (int r = 0; r < 6; r++) begin
         wide = (r % 2) == 1;
         if (wide) set_test(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         else      set_test(int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4);
         begin_run;
         npts = int'($urandom_range(1, 9));
         for (int p = 0; p < npts; p++) begin
            if (wide) begin
               rx = int'($urandom_range(0, 65535)) - 32768;
               ry = int'($urandom_range(0, 65535)) - 32768;
            end else begin
               rx = int'($urandom_range(0, 8)) - 4;
               ry = int'($urandom_range(0, 8)) - 4;
            end
            send_point(rx, ry, int'($urandom_range(0, 3)), p == npts - 1);
         end
         wait_done(edges);
         compute_model;
         tests_run++;
         if (count !== 3'(exp_count)) begin
            tests_failed++;
            $display("[TB] FAIL rand%0d_count: got %0d required %0d", r, count, exp_count);
         end
         tests_run++;
         if (class_label !== exp_class) begin
            tests_failed++;
            $display("[TB] FAIL rand%0d_class: got %0d required %0d", r, class_label, exp_class);
         end
         for (int i = 0; i < K; i++) begin
            rd_idx = 2'(i);
            #1;
            tests_run++;
            if (rd_dist !== exp_dist[i] || rd_label !== exp_lab[i] || rd_valid !== exp_valid[i]) begin
               tests_failed++;
               $display("[TB] FAIL rand%0d_entry%0d: got %0d/L%0d/v%0b required %0d/L%0d/v%0b",
                        r, i, rd_dist, rd_label, rd_valid, exp_dist[i], exp_lab[i], exp_valid[i]);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_midrun_reset;
      int edges;
      set_test(5, -3);
      begin_run;
      send_point(1, 2, 1, 1'b0);
      send_point(-3, 0, 2, 1'b0);
      send_point(4, 4, 3, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      rd_idx = 2'd0;
      #1;
      tests_run++;
      if ({pt_ready, busy, done} !== 3'b000 || count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL abort_state: ready/busy/done=%b count=%0d required 000/0",
                  {pt_ready, busy, done}, count);
      end
      tests_run++;
      if (rd_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL abort_list: entry0 valid=%0b required 0", rd_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      tx = 0;
      ty = 0;
      begin_run;
      send_point(5, -3, 4, 1'b0);
      send_point(1, 0, 2, 1'b0);
      send_point(-2, -2, 2, 1'b0);
      send_point(6, 1, 3, 1'b0);
      send_point(0, 3, 1, 1'b1);
      wait_done(edges);
      compute_model;
      tests_run++;
      if (class_label !== exp_class || count !== 3'(exp_count)) begin
         tests_failed++;
         $display("[TB] FAIL rerun_result: class=%0d count=%0d required %0d/%0d",
                  class_label, count, exp_class, exp_count);
      end
      for (int i = 0; i < K; i++) begin
         rd_idx = 2'(i);
         #1;
         tests_run++;
         if (rd_dist !== exp_dist[i] || rd_label !== exp_lab[i] || rd_valid !== exp_valid[i]) begin
            tests_failed++;
            $display("[TB] FAIL rerun_entry%0d: got %0d/L%0d/v%0b required %0d/L%0d/v%0b",
                     i, rd_dist, rd_label, rd_valid, exp_dist[i], exp_lab[i], exp_valid[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   // Hard stop in case a wait ever escapes its bound.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence.
   initial begin
      rst = 1'b1;
      start = 1'b0;
      test_we = 1'b0;
      test_idx = 1'b0;
      test_coord = '0;
      pt_valid = 1'b0;
      pt_coord = '0;
      pt_label = '0;
      pt_last = 1'b0;
      rd_idx = 2'd0;
      tx = 0;
      ty = 0;
      test_reset;
      test_handshake;
      test_basic;
      test_partial;
      test_ties;
      test_extremes;
      test_random;
      test_midrun_reset;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
